aidan_mcnay_serial_loader: RTL and testbench
============================================

# aidan_mcnay_serial_loader

Sequencing controller for the candidate-number register bank in the prime-detection datapath. It receives an NBITS-wide candidate serially, MSB first, one bit per valid cycle. It generates one-hot per-bit write enables into an internal bank of enabled one-bit registers. When the frame is complete, it presents the assembled word to the downstream prime checker over a valid/ready handshake.

## Interface
- NBITS, 16, width of the candidate word and number of bits per frame (must be ≥2)
- clk  input  1  clock; all state updates on posedge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  begin a new frame; bits are accepted from the following cycle
- bit_in  input  1  serial data bit
- bit_valid  input  1  bit_in carries a valid bit this cycle
- busy  output  1  high in LOAD and HOLD
- load_en  output  NBITS  one-hot write enable into the bank; bit NBITS-1-idx set when a bit is accepted
- bit_idx  output  $clog2(NBITS)  number of bits accepted in the current frame (0..NBITS-1)
- out_valid  output  1  assembled word available
- out_ready  input  1  downstream accepts word
- data  output  NBITS  assembled word, bit_in of first accepted bit in data[NBITS-1]

## Operation
- States: IDLE, LOAD, HOLD; encoding is free.
- IDLE: busy=0, out_valid=0, load_en=0; bit_valid ignored; start=1 -> LOAD, bit_idx<=0, bank cleared to 0.
- LOAD: busy=1.
  - bit_valid=1 -> load_en one-hot at position NBITS-1-bit_idx (combinational, same cycle); that bank bit <= bit_in.
  - Accepted bit with bit_idx<NBITS-1 -> bit_idx<=bit_idx+1.
  - Accepted bit with bit_idx==NBITS-1 -> HOLD, bit_idx<=0.
  - bit_valid=0 -> hold state, bit_idx, bank; load_en=0.
- start=1 in LOAD: abort and restart. bit_idx<=0, bank cleared, stay in LOAD, load_en=0 that cycle. start has priority over bit_valid.
- HOLD: busy=1, out_valid=1, data stable, load_en=0; bit_valid ignored.
  - out_ready=1 and start=0 -> IDLE.
  - out_ready=1 and start=1 -> LOAD directly, bank cleared, bit_idx<=0.
  - start=1 with out_ready=0: ignored, word held.
- data is always driven from the bank. It is only guaranteed meaningful while out_valid=1.
- bit_idx never exceeds NBITS-1 and has no wrap-around path.

## Timing
- reset=0 (any time, asynchronous): state<=IDLE, bit_idx<=0, bank<=0. Outputs immediately become busy=0, out_valid=0, load_en=0, data=0. Reset during LOAD or HOLD discards the frame.
- State updates on the first posedge with reset=1.
- start at cycle T -> busy=1 from T+1; the first bit can be accepted at T+1.
- Last (NBITS-th) bit accepted at cycle L -> out_valid=1 and data complete at L+1.
- Minimum frame time: 1 start cycle + NBITS bit cycles + 1 handshake cycle.
- Back-to-back frames with start coincident with handshake: the next frame's first bit lands one cycle after the handshake, with no IDLE bubble.
- Handshake transfer occurs on a cycle with out_valid=1 and out_ready=1. out_valid deasserts on the following cycle unless a new frame has completed, which is impossible within one cycle.

## Test plan
- Reset values: hold reset=0, then release. Required: busy=0, out_valid=0, load_en=0, data=0, bit_idx=0.
- Basic frame (NBITS=16): start, then 16 consecutive valid bits of 0xA5C3 MSB first, out_ready=1. Required: out_valid=1 with data=0xA5C3 on the cycle after the 16th bit; load_en walks 0x8000..0x0001; IDLE on the following cycle.
- Gapped input: same frame with bit_valid=0 inserted every third cycle. Required: data=0xA5C3; bit_idx and load_en are frozen during the gaps.
- Backpressure and chaining: out_ready=0 for 5 cycles after completion, then out_ready=1 with start=1. Required: data held at its value through the stall; next frame 0x0001 accepted with no IDLE cycle; final data=0x0001.
- Abort: start mid-frame after 7 bits of 0xFFFF, then 16 bits of 0x1234. Required: data=0x1234 and no residual ones.
- Asynchronous reset mid-LOAD and mid-HOLD. Required: outputs go to reset values without a clock edge, and a fresh frame afterwards completes correctly.

Source files
------------

// File: rtl/aidan_mcnay_serial_loader.sv
// Serial MSB-first candidate loader: one-hot write enables into a one-bit
// register bank, then presents the assembled word over valid/ready.
module aidan_mcnay_serial_loader #(
    parameter int unsigned NBITS = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       bit_in,
    input  logic                       bit_valid,
    output logic                       busy,
    output logic [NBITS-1:0]           load_en,
    output logic [$clog2(NBITS)-1:0]   bit_idx,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NBITS-1:0]           data
);

    localparam int unsigned IDXW = $clog2(NBITS);
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NBITS - 1);
    localparam logic [NBITS-1:0] MSB_ONE  = {1'b1, {(NBITS-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   bit_idx_q, bit_idx_d;
    logic [NBITS-1:0]  bank_q, bank_d;
    logic              busy_q, busy_d;
    logic              out_valid_q, out_valid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            bit_idx_q   <= '0;
            bank_q      <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            bank_q      <= bank_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next state, bank update and the same-cycle write enable.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        bank_d    = bank_q;
        load_en   = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LOAD;
                    bit_idx_d = '0;
                    bank_d    = '0;
                end
            end
            ST_LOAD: begin
                if (start) begin
                    bit_idx_d = '0;
                    bank_d    = '0;
                end else if (bit_valid) begin
                    load_en = MSB_ONE >> bit_idx_q;
                    bank_d  = (bank_q & ~load_en) | (bit_in ? load_en : '0);
                    if (bit_idx_q == LAST_IDX) begin
                        state_d   = ST_HOLD;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + IDXW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    if (start) begin
                        state_d   = ST_LOAD;
                        bit_idx_d = '0;
                        bank_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bit_idx_d = '0;
                bank_d    = '0;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_HOLD);
    end

    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign bit_idx   = bit_idx_q;
    assign data      = bank_q;

endmodule

// File: tb/tb_aidan_mcnay_serial_loader.sv
// Randomized and directed bench for the serial loader against a queue-based
// model of accepted bits.
module tb_aidan_mcnay_serial_loader;

    localparam int unsigned NBITS = 16;
    localparam int unsigned IDXW  = $clog2(NBITS);
    localparam int unsigned VW    = 2 + IDXW + 2 * NBITS;

    logic clk = 1'b0;
    logic reset;
    logic start_i, bit_i, bv_i, ready_i;
    logic busy, out_valid;
    logic [NBITS-1:0] load_en, data;
    logic [IDXW-1:0]  bit_idx;
    logic [VW-1:0]    obs;

    int n_checks = 0;
    int n_fail   = 0;

    // model: accepted bits in arrival order, plus frame phase
    bit loading, holding;
    bit q[$];

    always #5 clk = ~clk;

    aidan_mcnay_serial_loader #(.NBITS(NBITS)) dut (
        .clk(clk), .reset(reset), .start(start_i), .bit_in(bit_i),
        .bit_valid(bv_i), .busy(busy), .load_en(load_en), .bit_idx(bit_idx),
        .out_valid(out_valid), .out_ready(ready_i), .data(data)
    );

    assign obs = {busy, out_valid, bit_idx, load_en, data};

    function automatic logic [NBITS-1:0] model_word();
        logic [NBITS-1:0] w = '0;
        foreach (q[i]) w[NBITS-1-i] = q[i];
        return w;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        logic [NBITS-1:0] le = '0;
        int idx = loading ? q.size() : 0;
        if (loading && !start_i && bv_i) le[NBITS-1-q.size()] = 1'b1;
        return {loading | holding, holding, IDXW'(idx), le, model_word()};
    endfunction

    function automatic void model_reset();
        loading = 0; holding = 0; q.delete();
    endfunction

    function automatic void model_step();
        if (loading) begin
            if (start_i) q.delete();
            else if (bv_i) begin
                q.push_back(bit_i);
                if (q.size() == NBITS) begin loading = 0; holding = 1; end
            end
        end else if (holding) begin
            if (ready_i) begin
                holding = 0;
                if (start_i) begin loading = 1; q.delete(); end
            end
        end else if (start_i) begin
            loading = 1; q.delete();
        end
    endfunction

    // Advance one cycle: model follows the edge, new inputs land mid-cycle.
    task automatic drive(input logic s, input logic bv, input logic b, input logic r);
        @(posedge clk);
        if (reset) model_step();
        @(negedge clk);
        start_i = s; bv_i = bv; bit_i = b; ready_i = r;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; model_reset();
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b1, 1'b1);
        if (obs !== '0) begin n_fail++; $display("FAIL reset_held: got %h want 0", obs); end
        n_checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        if (obs !== exp_vec() || obs !== '0) begin n_fail++; $display("FAIL reset_release: got %h want 0", obs); end
        n_checks++;
    endtask

    task automatic test_basic();
        logic [NBITS-1:0] w = 16'hA5C3;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NBITS; i++) begin
            drive(1'b0, 1'b1, w[NBITS-1-i], 1'b1);
            if (obs !== exp_vec() || load_en !== (16'h8000 >> i)) begin
                n_fail++; $display("FAIL basic_bit%0d: got %h want %h", i, obs, exp_vec());
            end
            n_checks++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || !out_valid || data !== 16'hA5C3) begin
            n_fail++; $display("FAIL basic_done: got %h want %h", obs, exp_vec());
        end
        n_checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL basic_idle: got %h want %h", obs, exp_vec());
        end
        n_checks++;
    endtask

    task automatic test_gapped();
        logic [NBITS-1:0] w = 16'hA5C3;
        int n = 0;
        int c = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        while (n < NBITS) begin
            if (c % 3 == 2) drive(1'b0, 1'b0, 1'b1, 1'b1);
            else begin drive(1'b0, 1'b1, w[NBITS-1-n], 1'b1); n++; end
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL gapped_c%0d: got %h want %h", c, obs, exp_vec()); end
            n_checks++;
            c++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || data !== 16'hA5C3 || !out_valid) begin
            n_fail++; $display("FAIL gapped_done: got %h want %h", obs, exp_vec());
        end
        n_checks++;
    endtask

    task automatic test_backpressure_chain();
        logic [NBITS-1:0] w = NBITS'($urandom);
        logic [NBITS-1:0] w2 = 16'h0001;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < NBITS; i++) drive(1'b0, 1'b1, w[NBITS-1-i], 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(i == 2, 1'b1, 1'b0, 1'b0);
            if (obs !== exp_vec() || data !== w || !out_valid) begin
                n_fail++; $display("FAIL stall%0d: got %h want %h", i, obs, exp_vec());
            end
            n_checks++;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NBITS; i++) begin
            drive(1'b0, 1'b1, w2[NBITS-1-i], 1'b0);
            if (obs !== exp_vec() || busy !== 1'b1 || out_valid !== 1'b0) begin
                n_fail++; $display("FAIL chain_bit%0d: got %h want %h", i, obs, exp_vec());
            end
            n_checks++;
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || data !== 16'h0001 || !out_valid) begin
            n_fail++; $display("FAIL chain_done: got %h want %h", obs, exp_vec());
        end
        n_checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_abort();
        logic [NBITS-1:0] w = 16'h1234;
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) drive(1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        if (obs !== exp_vec() || load_en !== '0) begin
            n_fail++; $display("FAIL abort_cycle: got %h want %h", obs, exp_vec());
        end
        n_checks++;
        for (int i = 0; i < NBITS; i++) drive(1'b0, 1'b1, w[NBITS-1-i], 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || data !== 16'h1234) begin
            n_fail++; $display("FAIL abort_done: got %h want %h", obs, exp_vec());
        end
        n_checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_async_reset();
        logic [NBITS-1:0] w = NBITS'($urandom);
        for (int phase = 0; phase < 2; phase++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            for (int i = 0; i < (phase == 0 ? 5 : NBITS); i++) drive(1'b0, 1'b1, 1'b1, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            #1 reset = 1'b0; model_reset();
            #1;
            if (obs !== '0) begin n_fail++; $display("FAIL async_reset_p%0d: got %h want 0", phase, obs); end
            n_checks++;
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            reset = 1'b1;
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < NBITS; i++) drive(1'b0, 1'b1, w[NBITS-1-i], 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        if (obs !== exp_vec() || data !== w || !out_valid) begin
            n_fail++; $display("FAIL post_reset_frame: got %h want %h", obs, exp_vec());
        end
        n_checks++;
        drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                  1'($urandom), $urandom_range(0, 2) != 0);
            if (obs !== exp_vec()) begin n_fail++; $display("FAIL random_c%0d: got %h want %h", i, obs, exp_vec()); end
            n_checks++;
        end
    endtask

    initial begin
        start_i = 1'b0; bv_i = 1'b0; bit_i = 1'b0; ready_i = 1'b0; reset = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_gapped();
        test_backpressure_chain();
        test_abort();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
